// File: rtl/arm_pkg.sv
// Shared ARM-core constants: word/register widths, field widths, exe_cmd codes.
// Used by the register file, decoder, ID/EXE register and EXE stage.
package arm_pkg;

    localparam int WORD_LEN     = 32;
    localparam int REG_ADDR_LEN = 4;
    localparam int EXE_CMD_LEN  = 4;
    localparam int SHIFT_OP_LEN = 12;
    localparam int SIMM24_LEN   = 24;

    localparam logic [EXE_CMD_LEN-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_LEN-1:0] EXE_EOR = 4'b1000;

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE bundle: decoded fields in (_in, driven by ID) and registered out (_out).
// Modports: master = ID/consumer side, slave = the pipeline register.
import arm_pkg::*;

interface id_exe_stage_reg_if #(
    parameter int WordLen    = WORD_LEN,
    parameter int RegAddrLen = REG_ADDR_LEN
);
    logic [WordLen-1:0]      pc_in,  pc_out;
    logic [WordLen-1:0]      val_rn_in, val_rn_out;
    logic [WordLen-1:0]      val_rm_in, val_rm_out;
    logic                    imm_in, imm_out;
    logic [SHIFT_OP_LEN-1:0] shift_operand_in, shift_operand_out;
    logic [SIMM24_LEN-1:0]   signed_imm_24_in, signed_imm_24_out;
    logic [RegAddrLen-1:0]   dest_in, dest_out;
    logic [EXE_CMD_LEN-1:0]  exe_cmd_in, exe_cmd_out;
    logic                    status_c_in, status_c_out;
    logic                    mem_read_in, mem_read_out;
    logic                    mem_write_in, mem_write_out;
    logic                    wb_en_in, wb_en_out;
    logic                    b_in, b_out;
    logic                    s_in, s_out;
    logic                    valid_in, valid_out;
    logic [RegAddrLen-1:0]   src1_in, src1_out;
    logic [RegAddrLen-1:0]   src2_in, src2_out;

    modport master (
        output pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm_24_in, dest_in, exe_cmd_in, status_c_in,
               mem_read_in, mem_write_in, wb_en_in, b_in, s_in,
               valid_in, src1_in, src2_in,
        input  pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
               signed_imm_24_out, dest_out, exe_cmd_out, status_c_out,
               mem_read_out, mem_write_out, wb_en_out, b_out, s_out,
               valid_out, src1_out, src2_out
    );

    modport slave (
        input  pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm_24_in, dest_in, exe_cmd_in, status_c_in,
               mem_read_in, mem_write_in, wb_en_in, b_in, s_in,
               valid_in, src1_in, src2_in,
        output pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
               signed_imm_24_out, dest_out, exe_cmd_out, status_c_out,
               mem_read_out, mem_write_out, wb_en_out, b_out, s_out,
               valid_out, src1_out, src2_out
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline field register. Priority: rst (->0), flush (->FlushVal),
// freeze (hold), else load d. Ports: clk, rst, flush, freeze, d, q.
module pipe_reg #(
    parameter int           W        = 1,
    parameter logic [W-1:0] FlushVal = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         freeze,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst)          r_q <= '0;
        else if (flush)   r_q <= FlushVal;
        else if (!freeze) r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: one-cycle registered pass-through of all fields.
// Ports: clk, rst (sync, active-high), freeze (hold), flush (bubble), bus (slave).
// Macro FORWARDING_EN: when defined, src1/src2 register numbers are carried;
// otherwise src1_out/src2_out are tied to zero and no registers are built.
import arm_pkg::*;

module id_exe_stage_reg #(
    parameter int WordLen    = WORD_LEN,
    parameter int RegAddrLen = REG_ADDR_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    id_exe_stage_reg_if.slave  bus
);
    // No bypass on val_rn/val_rm: the register file writes on the falling
    // edge, so a same-cycle write-back is already visible here.

    pipe_reg #(.W(WordLen)) u_pc (
        .clk, .rst, .flush, .freeze,
        .d(bus.pc_in), .q(bus.pc_out));

    pipe_reg #(.W(WordLen)) u_rn (
        .clk, .rst, .flush, .freeze,
        .d(bus.val_rn_in), .q(bus.val_rn_out));

    pipe_reg #(.W(WordLen)) u_rm (
        .clk, .rst, .flush, .freeze,
        .d(bus.val_rm_in), .q(bus.val_rm_out));

    pipe_reg #(.W(1)) u_imm (
        .clk, .rst, .flush, .freeze,
        .d(bus.imm_in), .q(bus.imm_out));

    pipe_reg #(.W(SHIFT_OP_LEN)) u_shop (
        .clk, .rst, .flush, .freeze,
        .d(bus.shift_operand_in), .q(bus.shift_operand_out));

    pipe_reg #(.W(SIMM24_LEN)) u_simm (
        .clk, .rst, .flush, .freeze,
        .d(bus.signed_imm_24_in), .q(bus.signed_imm_24_out));

    pipe_reg #(.W(RegAddrLen)) u_dest (
        .clk, .rst, .flush, .freeze,
        .d(bus.dest_in), .q(bus.dest_out));

    pipe_reg #(.W(EXE_CMD_LEN)) u_cmd (
        .clk, .rst, .flush, .freeze,
        .d(bus.exe_cmd_in), .q(bus.exe_cmd_out));

    pipe_reg #(.W(1)) u_c (
        .clk, .rst, .flush, .freeze,
        .d(bus.status_c_in), .q(bus.status_c_out));

    pipe_reg #(.W(1)) u_mr (
        .clk, .rst, .flush, .freeze,
        .d(bus.mem_read_in), .q(bus.mem_read_out));

    pipe_reg #(.W(1)) u_mw (
        .clk, .rst, .flush, .freeze,
        .d(bus.mem_write_in), .q(bus.mem_write_out));

    pipe_reg #(.W(1)) u_wb (
        .clk, .rst, .flush, .freeze,
        .d(bus.wb_en_in), .q(bus.wb_en_out));

    pipe_reg #(.W(1)) u_b (
        .clk, .rst, .flush, .freeze,
        .d(bus.b_in), .q(bus.b_out));

    pipe_reg #(.W(1)) u_s (
        .clk, .rst, .flush, .freeze,
        .d(bus.s_in), .q(bus.s_out));

    // valid_out is the BUBBLE(0)/VALID(1) state: flush and rst force BUBBLE.
    pipe_reg #(.W(1)) u_valid (
        .clk, .rst, .flush, .freeze,
        .d(bus.valid_in), .q(bus.valid_out));

`ifdef FORWARDING_EN
    pipe_reg #(.W(RegAddrLen)) u_src1 (
        .clk, .rst, .flush, .freeze,
        .d(bus.src1_in), .q(bus.src1_out));

    pipe_reg #(.W(RegAddrLen)) u_src2 (
        .clk, .rst, .flush, .freeze,
        .d(bus.src2_in), .q(bus.src2_out));
`else
    logic w_unused_src;
    assign w_unused_src = ^{bus.src1_in, bus.src2_in};
    assign bus.src1_out = '0;
    assign bus.src2_out = '0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios followed by
// random traffic, compared against a bundle-level reference model.
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic        c;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic        valid;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } bun_t;

    logic clk = 1'b0;
    logic rst, freeze, flush;
    bun_t din, dout, exp_q;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rf [16];

    always #5 clk = ~clk;

    id_exe_stage_reg_if #(.WordLen(32), .RegAddrLen(4)) bus ();

    id_exe_stage_reg #(.WordLen(32), .RegAddrLen(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bus(bus));

    assign bus.pc_in            = din.pc;
    assign bus.val_rn_in        = din.rn;
    assign bus.val_rm_in        = din.rm;
    assign bus.imm_in           = din.imm;
    assign bus.shift_operand_in = din.shop;
    assign bus.signed_imm_24_in = din.simm;
    assign bus.dest_in          = din.dest;
    assign bus.exe_cmd_in       = din.cmd;
    assign bus.status_c_in      = din.c;
    assign bus.mem_read_in      = din.mr;
    assign bus.mem_write_in     = din.mw;
    assign bus.wb_en_in         = din.wb;
    assign bus.b_in             = din.b;
    assign bus.s_in             = din.s;
    assign bus.valid_in         = din.valid;
    assign bus.src1_in          = din.src1;
    assign bus.src2_in          = din.src2;

    assign dout = '{bus.pc_out, bus.val_rn_out, bus.val_rm_out,
                    bus.imm_out, bus.shift_operand_out,
                    bus.signed_imm_24_out, bus.dest_out,
                    bus.exe_cmd_out, bus.status_c_out,
                    bus.mem_read_out, bus.mem_write_out,
                    bus.wb_en_out, bus.b_out, bus.s_out,
                    bus.valid_out, bus.src1_out, bus.src2_out};

    // Stage contents after an edge: reset/flush -> empty bubble,
    // stall -> unchanged, otherwise the presented instruction.
    function automatic bun_t model_next(bun_t cur, bun_t in,
                                        logic r, logic fl, logic fr);
        bun_t n;
        if (r || fl) return '0;
        if (fr) return cur;
        n = in;
`ifndef FORWARDING_EN
        n.src1 = '0;
        n.src2 = '0;
`endif
        return n;
    endfunction

    task automatic check(input string tag,
                         input logic [159:0] obs,
                         input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge: advance the model, then sample 1 time unit later.
    task automatic step(input string tag);
        exp_q = model_next(exp_q, din, rst, flush, freeze);
        @(posedge clk);
        #1;
        check(tag, 160'(dout), 160'(exp_q));
    endtask

    initial begin
        logic [159:0] rnd;
        foreach (rf[i]) rf[i] = 32'h0;
        exp_q  = '0;
        rst    = 1'b1;
        flush  = 1'b0;
        freeze = 1'b0;
        din    = '1;

        @(negedge clk);
        step("reset_c1");
        step("reset_c2");
        check("reset_valid", 160'(bus.valid_out), 160'(1'b0));

        rst  = 1'b0;
        din  = '0;
        din.pc    = 32'h0000_0008;
        din.rn    = 32'h1234_5678;
        din.dest  = 4'd3;
        din.wb    = 1'b1;
        din.valid = 1'b1;
        step("load");
        check("load_pc", 160'(bus.pc_out), 160'(32'h8));
        check("load_rn", 160'(bus.val_rn_out), 160'(32'h1234_5678));
        check("load_dest", 160'(bus.dest_out), 160'(4'd3));

        freeze = 1'b1;
        din.pc = 32'h0000_000C;
        din.rn = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            step("freeze_hold");
            check("freeze_pc", 160'(bus.pc_out), 160'(32'h8));
        end
        freeze = 1'b0;
        step("freeze_release");
        check("release_pc", 160'(bus.pc_out), 160'(32'hC));

        flush     = 1'b1;
        freeze    = 1'b1;
        din.wb    = 1'b1;
        din.mw    = 1'b1;
        din.valid = 1'b1;
        step("flush_freeze");
        check("flush_all_zero", 160'(dout), 160'(0));

        flush  = 1'b0;
        freeze = 1'b0;
        din.valid = 1'b1;
        step("reload");
        freeze = 1'b1;
        flush  = 1'b1;
        rst    = 1'b1;
        step("rst_mid_stall");
        check("rst_stall_zero", 160'(dout), 160'(0));
        rst    = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;

        // Register file written on the falling edge; the read port
        // value seen by the stage register is the freshly written one.
        din.rn = rf[5];
        @(negedge clk);
        rf[5]  = 32'hDEAD_BEEF;
        din.rn = rf[5];
        step("negedge_wb");
        check("negedge_rn", 160'(bus.val_rn_out), 160'(32'hDEAD_BEEF));

        din.src1 = 4'd7;
        din.src2 = 4'd9;
        step("src_fwd");
`ifdef FORWARDING_EN
        check("src1_out", 160'(bus.src1_out), 160'(4'd7));
`else
        check("src1_out", 160'(bus.src1_out), 160'(4'd0));
`endif

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            din    = rnd[154:0];
            rst    = ($urandom_range(0, 31) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
